// File: rtl/tt_um_uwasic_accum_array.sv
// Multi-channel accumulator array with valid/ready handshakes.
// Each transaction can pass a sum, wrap-accumulate, saturate-accumulate or read-and-clear one channel.
module tt_um_uwasic_accum_array #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  localparam int CH_W    = $clog2(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    in_a,
  input  logic [WIDTH-1:0]    in_b,
  input  logic [CH_W-1:0]     in_chan,
  input  logic [1:0]          in_mode,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    out_data,
  output logic [CH_W-1:0]     out_chan,
  output logic                out_ovf,
  output logic [CHANNELS-1:0] ovf_sticky
);

  localparam logic [1:0] MODE_PASS = 2'b00;
  localparam logic [1:0] MODE_WRAP = 2'b01;
  localparam logic [1:0] MODE_SAT  = 2'b10;
  localparam logic [1:0] MODE_RDCL = 2'b11;

  logic [CHANNELS-1:0][WIDTH-1:0] w_acc;
  logic [WIDTH-1:0]               w_acc_sel;
  logic [WIDTH+1:0]               w_sum_ab;
  logic [WIDTH+1:0]               w_sum_acc;
  logic [WIDTH-1:0]               w_res;
  logic                           w_ovf;
  logic                           w_accept;

  logic                           r_out_valid;
  logic [WIDTH-1:0]               r_out_data;
  logic [CH_W-1:0]                r_out_chan;
  logic                           r_out_ovf;

  assign in_ready  = !rst && (!r_out_valid || out_ready);
  assign w_accept  = in_valid && in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_chan  = r_out_chan;
  assign out_ovf   = r_out_ovf;

  // Two guard bits cover acc + a + b without loss.
  assign w_acc_sel = w_acc[in_chan];
  assign w_sum_ab  = {2'b00, in_a} + {2'b00, in_b};
  assign w_sum_acc = {2'b00, w_acc_sel} + w_sum_ab;

  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    case (in_mode)
      MODE_PASS: begin
        w_res = w_sum_ab[WIDTH-1:0];
        w_ovf = |w_sum_ab[WIDTH+1:WIDTH];
      end
      MODE_WRAP: begin
        w_res = w_sum_acc[WIDTH-1:0];
        w_ovf = |w_sum_acc[WIDTH+1:WIDTH];
      end
      MODE_SAT: begin
        w_ovf = |w_sum_acc[WIDTH+1:WIDTH];
        w_res = w_ovf ? '1 : w_sum_acc[WIDTH-1:0];
      end
      MODE_RDCL: begin
        w_res = w_acc_sel;
        w_ovf = ovf_sticky[in_chan];
      end
      default: ;
    endcase
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    logic             w_sel;
    logic [WIDTH-1:0] r_acc;
    logic             r_sticky;

    assign w_sel         = w_accept && (in_chan == CH_W'(g));
    assign w_acc[g]      = r_acc;
    assign ovf_sticky[g] = r_sticky;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_acc    <= '0;
        r_sticky <= 1'b0;
      end else if (w_sel) begin
        case (in_mode)
          MODE_PASS: if (w_ovf) r_sticky <= 1'b1;
          MODE_WRAP, MODE_SAT: begin
            r_acc <= w_res;
            if (w_ovf) r_sticky <= 1'b1;
          end
          default: begin
            r_acc    <= '0;
            r_sticky <= 1'b0;
          end
        endcase
      end
    end
  end

  // Output stage loads on every accept; a consume without accept only drops valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_chan  <= '0;
      r_out_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_res;
      r_out_chan  <= in_chan;
      r_out_ovf   <= w_ovf;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tt_um_uwasic_accum_array.sv
// Directed and randomized checks of the accumulator array against an arithmetic reference model.
module tb_tt_um_uwasic_accum_array;
  localparam int WIDTH = 8;
  localparam int CH    = 4;
  localparam int MAXV  = 1 << WIDTH;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0, in_ready;
  logic [WIDTH-1:0] in_a = '0, in_b = '0;
  logic [1:0]       in_chan = '0, in_mode = '0;
  logic             out_valid, out_ready = 1'b1;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       out_chan;
  logic             out_ovf;
  logic [CH-1:0]    ovf_sticky;

  int total = 0;
  int bad   = 0;

  // reference model state
  int unsigned macc[CH];
  bit          msticky[CH];

  tt_um_uwasic_accum_array #(.WIDTH(WIDTH), .CHANNELS(CH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_chan(in_chan), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_chan(out_chan), .out_ovf(out_ovf), .ovf_sticky(ovf_sticky)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input int a, input int b, input int ch, input int mode);
    in_valid = v;
    in_a     = WIDTH'(a);
    in_b     = WIDTH'(b);
    in_chan  = 2'(ch);
    in_mode  = 2'(mode);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    out_ready = 1'b1;
    cyc();
    rst = 1'b0;
    for (int c = 0; c < CH; c++) begin macc[c] = 0; msticky[c] = 0; end
  endtask

  task automatic model_txn(input int a, input int b, input int ch, input int mode,
                           output int res, output bit ovf);
    int s;
    res = 0; ovf = 0;
    case (mode)
      0: begin s = a + b; res = s % MAXV; ovf = (s >= MAXV); end
      1: begin s = macc[ch] + a + b; res = s % MAXV; ovf = (s >= MAXV); macc[ch] = res; end
      2: begin
        s = macc[ch] + a + b;
        if (s > MAXV - 1) begin res = MAXV - 1; ovf = 1; end
        else begin res = s; ovf = 0; end
        macc[ch] = res;
      end
      default: begin res = macc[ch]; ovf = msticky[ch]; macc[ch] = 0; msticky[ch] = 0; end
    endcase
    if (mode != 3 && ovf) msticky[ch] = 1;
  endtask

  task automatic test_reset();
    rst = 1'b1; out_ready = 1'b1; drive(1, 1, 1, 0, 1);
    cyc(); cyc();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
    rst = 1'b0; drive(0, 0, 0, 0, 0); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (out_data !== 8'd0 || out_chan !== 2'd0 || out_ovf !== 1'b0)
      begin bad++; $display("FAIL reset_outputs data=%0d chan=%0d ovf=%b want 0/0/0", out_data, out_chan, out_ovf); end
    total++; if (ovf_sticky !== 4'h0) begin bad++; $display("FAIL reset_sticky got=%h want=0", ovf_sticky); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_pass_sum();
    do_reset();
    drive(1, 200, 100, 0, 0); cyc();
    drive(1, 0, 0, 0, 3);
    total++; if (out_valid !== 1'b1 || out_data !== 8'd44 || out_ovf !== 1'b1)
      begin bad++; $display("FAIL pass_sum v=%b data=%0d ovf=%b want 1/44/1", out_valid, out_data, out_ovf); end
    total++; if (ovf_sticky[0] !== 1'b1) begin bad++; $display("FAIL pass_sticky got=%b want=1", ovf_sticky[0]); end
    cyc(); drive(0, 0, 0, 0, 0);
    total++; if (out_valid !== 1'b1 || out_data !== 8'd0 || out_ovf !== 1'b1)
      begin bad++; $display("FAIL pass_readclr v=%b data=%0d ovf=%b want 1/0/1", out_valid, out_data, out_ovf); end
    cyc();
    total++; if (out_valid !== 1'b0 || ovf_sticky[0] !== 1'b0)
      begin bad++; $display("FAIL pass_cleared v=%b sticky=%b want 0/0", out_valid, ovf_sticky[0]); end
  endtask

  task automatic test_wrap_back_to_back();
    do_reset();
    drive(1, 10, 5, 1, 1); cyc();
    drive(1, 20, 0, 1, 1); #1;
    total++; if (out_valid !== 1'b1 || out_data !== 8'd15 || out_chan !== 2'd1)
      begin bad++; $display("FAIL wrap_first v=%b data=%0d chan=%0d want 1/15/1", out_valid, out_data, out_chan); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL wrap_ready got=%b want=1", in_ready); end
    cyc(); drive(0, 0, 0, 0, 0);
    total++; if (out_valid !== 1'b1 || out_data !== 8'd35 || out_chan !== 2'd1)
      begin bad++; $display("FAIL wrap_second v=%b data=%0d chan=%0d want 1/35/1", out_valid, out_data, out_chan); end
    cyc();
  endtask

  task automatic test_sat();
    do_reset();
    drive(1, 250, 0, 2, 2); cyc();
    drive(1, 3, 4, 2, 2);
    total++; if (out_data !== 8'd250 || out_ovf !== 1'b0)
      begin bad++; $display("FAIL sat_first data=%0d ovf=%b want 250/0", out_data, out_ovf); end
    cyc(); drive(1, 0, 0, 2, 3);
    total++; if (out_data !== 8'd255 || out_ovf !== 1'b1 || ovf_sticky[2] !== 1'b1)
      begin bad++; $display("FAIL sat_clip data=%0d ovf=%b sticky=%b want 255/1/1", out_data, out_ovf, ovf_sticky[2]); end
    cyc(); drive(1, 0, 0, 2, 3);
    total++; if (out_data !== 8'd255 || out_ovf !== 1'b1)
      begin bad++; $display("FAIL sat_read data=%0d ovf=%b want 255/1", out_data, out_ovf); end
    total++; if (ovf_sticky[2] !== 1'b0) begin bad++; $display("FAIL sat_sticky_clr got=%b want=0", ovf_sticky[2]); end
    cyc(); drive(0, 0, 0, 0, 0);
    total++; if (out_data !== 8'd0 || out_ovf !== 1'b0)
      begin bad++; $display("FAIL sat_acc_clr data=%0d ovf=%b want 0/0", out_data, out_ovf); end
    cyc();
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    drive(1, 1, 2, 0, 1); cyc();
    drive(1, 4, 4, 0, 1);
    for (int i = 0; i < 5; i++) begin
      #1;
      total++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'd3 || out_chan !== 2'd0 || out_ovf !== 1'b0)
        begin bad++; $display("FAIL stall_%0d rdy=%b v=%b data=%0d want 0/1/3", i, in_ready, out_valid, out_data); end
      cyc();
    end
    out_ready = 1'b1; #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stall_release_ready got=%b want=1", in_ready); end
    cyc(); drive(0, 0, 0, 0, 0);
    total++; if (out_valid !== 1'b1 || out_data !== 8'd11)
      begin bad++; $display("FAIL stall_next v=%b data=%0d want 1/11", out_valid, out_data); end
    cyc();
    total++; if (out_valid !== 1'b0 || out_data !== 8'd11)
      begin bad++; $display("FAIL drain v=%b data=%0d want 0/11", out_valid, out_data); end
  endtask

  task automatic test_isolation();
    do_reset();
    drive(1, 3, 4, 3, 1); cyc();
    for (int c = 0; c < CH; c++) begin
      drive(1, 0, 0, c, 3); cyc();
      total++; if (out_valid !== 1'b1 || out_chan !== 2'(c) || out_data !== ((c == 3) ? 8'd7 : 8'd0))
        begin bad++; $display("FAIL iso_ch%0d v=%b chan=%0d data=%0d want data=%0d", c, out_valid, out_chan, out_data, (c == 3) ? 7 : 0); end
    end
    drive(0, 0, 0, 0, 0); cyc();
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    drive(1, 200, 100, 0, 0); cyc();
    drive(1, 10, 5, 1, 1); cyc();
    drive(1, 20, 0, 1, 1); cyc();
    drive(0, 0, 0, 0, 0); out_ready = 1'b0; cyc(); cyc();
    rst = 1'b1; cyc();
    rst = 1'b0; #1;
    total++; if (out_valid !== 1'b0 || ovf_sticky !== 4'h0 || in_ready !== 1'b1)
      begin bad++; $display("FAIL rst_stall v=%b sticky=%h rdy=%b want 0/0/1", out_valid, ovf_sticky, in_ready); end
    out_ready = 1'b1;
    for (int c = 0; c < CH; c++) begin
      drive(1, 0, 0, c, 3); cyc();
      total++; if (out_data !== 8'd0 || out_ovf !== 1'b0)
        begin bad++; $display("FAIL rst_acc_ch%0d data=%0d ovf=%b want 0/0", c, out_data, out_ovf); end
    end
    drive(0, 0, 0, 0, 0); cyc();
    for (int c = 0; c < CH; c++) begin macc[c] = 0; msticky[c] = 0; end
  endtask

  task automatic test_random();
    bit ev = 0, eovf = 0, acc_ok;
    int ed = 0, ech = 0, res, a, b, ch, md;
    bit ov;
    logic [CH-1:0] es;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < CH; c++) es[c] = msticky[c];
      total++; if (out_valid !== ev) begin bad++; $display("FAIL rnd_valid cyc=%0d got=%b want=%b", i, out_valid, ev); end
      if (ev) begin
        total++; if (out_data !== WIDTH'(ed) || out_chan !== 2'(ech) || out_ovf !== eovf)
          begin bad++; $display("FAIL rnd_data cyc=%0d got=%0d/%0d/%b want=%0d/%0d/%b", i, out_data, out_chan, out_ovf, ed, ech, eovf); end
      end
      total++; if (ovf_sticky !== es) begin bad++; $display("FAIL rnd_sticky cyc=%0d got=%h want=%h", i, ovf_sticky, es); end
      a = $urandom_range(MAXV - 1); b = $urandom_range(MAXV - 1);
      if ($urandom_range(1)) b = $urandom_range(15);
      ch = $urandom_range(CH - 1); md = $urandom_range(3);
      drive($urandom_range(3) != 0, a, b, ch, md);
      out_ready = ($urandom_range(3) != 0);
      #1;
      acc_ok = !ev || out_ready;
      total++; if (in_ready !== acc_ok) begin bad++; $display("FAIL rnd_ready cyc=%0d got=%b want=%b", i, in_ready, acc_ok); end
      if (in_valid && acc_ok) begin
        model_txn(a, b, ch, md, res, ov);
        ev = 1; ed = res; ech = ch; eovf = ov;
      end else if (ev && out_ready) begin
        ev = 0;
      end
      cyc();
    end
    drive(0, 0, 0, 0, 0); out_ready = 1'b1; cyc();
  endtask

  initial begin
    test_reset();
    test_pass_sum();
    test_wrap_back_to_back();
    test_sat();
    test_backpressure();
    test_isolation();
    test_reset_mid_stall();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tt_um_uwasic_accum_array.md
Name: tt_um_uwasic_accum_array

Overview:
Parametrised successor to the onboarding combinational adder. It provides CHANNELS independent accumulators, each WIDTH bits wide. The block accepts operand pairs over a valid/ready handshake and applies a per-transaction mode: pass-sum, wrapping accumulate, saturating accumulate, or read-and-clear. Results leave through a registered valid/ready output stage. It sits behind the top-level pin mux, with ui_in and uio_in feeding the operands.

Parameters:
WIDTH, 8, operand, accumulator and result width in bits (>=2)
CHANNELS, 4, number of independent accumulators; power of two, >=2; CH_W = $clog2(CHANNELS) derived internally

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
in_valid  input  1  operand transaction valid
in_ready  output  1  block can accept a transaction this cycle
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B
in_chan  input  CH_W  target channel
in_mode  input  2  00 pass-sum, 01 wrap-accumulate, 10 sat-accumulate, 11 read-clear
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_data  output  WIDTH  result
out_chan  output  CH_W  channel of result
out_ovf  output  1  overflow/saturation occurred in this transaction
ovf_sticky  output  CHANNELS  per-channel sticky overflow flags

Behaviour:
- Single clock domain, everything on posedge clk. rst is synchronous, active-high, and overrides all other activity.
- Reset values: all acc[c]=0, ovf_sticky=0, out_valid=0, out_data=0, out_chan=0, out_ovf=0. in_ready=0 while rst=1.
- in_ready = !rst && (!out_valid || out_ready), combinational. Accept = in_valid && in_ready.
- Latency is 1: an accept in cycle N gives out_valid=1 with the result in cycle N+1.
- Output stall: while out_valid && !out_ready, out_data, out_chan and out_ovf hold stable and no new accept occurs.
- Simultaneous consume and accept: out_valid stays 1 and the output register loads the new result. Full throughput is one transaction per cycle.
- Consume with no accept: out_valid drops to 0. out_data holds its last value.
- Intermediate arithmetic uses WIDTH+2 bits, zero-extended and unsigned.
- Mode 00 (pass-sum): result = (a+b) mod 2^WIDTH; out_ovf = (a+b) >= 2^WIDTH. acc is unchanged.
- Mode 01 (wrap-accumulate): s = acc[c]+a+b; result = acc[c]_next = s mod 2^WIDTH; out_ovf = s >= 2^WIDTH.
- Mode 10 (sat-accumulate): s as in mode 01. If s > 2^WIDTH-1, then result = acc[c]_next = all-ones and out_ovf = 1. Otherwise result = acc[c]_next = s and out_ovf = 0.
- Mode 11 (read-clear): result = old acc[c]; out_ovf = old ovf_sticky[c]; acc[c]_next = 0; ovf_sticky[c]_next = 0.
- ovf_sticky[c] is set on any accepted mode 00/01/10 transaction to channel c with out_ovf=1. It is cleared only by mode 11 on c or by reset.
- Back-to-back transactions to the same channel: each accept uses the acc value already updated by the previous accept. There is no hazard and no bubble.
- Only the addressed channel changes. Other channels hold their values.
- Reset asserted mid-stall discards the pending result. out_valid is 0 in the cycle after the reset edge.

Test Plan:
- Reset, then WIDTH=8, mode 00, a=200, b=100, ch0 -> next cycle out_valid=1, out_data=44, out_ovf=1, ovf_sticky[0]=1, acc[0] still 0 (confirm with mode 11 read: out_data=0, out_ovf=1, then sticky cleared).
- Mode 01 on ch1 with (10,5), then (20,0) back-to-back, out_ready=1 -> results 15 then 35, out_chan=1, one transaction per cycle, in_ready stays 1.
- Mode 10 on ch2: (250,0), then (3,4) -> 250, then 255 with out_ovf=1, ovf_sticky[2]=1. Mode 11 ch2 -> out_data=255, out_ovf=1, after which acc[2]=0 and sticky[2]=0.
- Backpressure: hold out_ready=0 with a result pending and drive in_valid=1 -> in_ready=0, outputs stable for 5 cycles, no acc change. Raise out_ready -> the pending result is consumed and the new operand is accepted the same cycle.
- Channel isolation: accumulate 7 on ch3 only -> read-clear ch0..2 returns 0, read-clear ch3 returns 7.
- Assert rst for 1 cycle during a stall with acc[1]=35 -> out_valid=0, all acc=0, ovf_sticky=0, in_ready=1 the cycle after rst deasserts.
